// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array controller: state encoding,
// default geometry and derived pipeline-depth helpers.
package sa_pkg;

  localparam int N_DEF       = 8;
  localparam int ROWS_DEF    = 8;
  localparam int COLS_DEF    = 8;
  localparam int LEN_W_DEF   = 12;
  localparam int MAC_LAT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Advances needed after the last beat until the far corner column finishes.
  function automatic int drain_cyc(input int rows, input int cols, input int mac_lat);
    return rows + cols - 2 + mac_lat;
  endfunction

  function automatic int tok_depth(input int rows, input int cols, input int mac_lat);
    return rows + cols - 1 + mac_lat;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sa_ctrl_if.sv
// Host/array-facing signal bundle of the controller; the controller takes the
// slave view, the host/array side the master view.
interface sa_ctrl_if #(
  parameter int N     = sa_pkg::N_DEF,
  parameter int ROWS  = sa_pkg::ROWS_DEF,
  parameter int COLS  = sa_pkg::COLS_DEF,
  parameter int LEN_W = sa_pkg::LEN_W_DEF,
  parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
);

  logic               start;
  logic [LEN_W-1:0]   cfg_len;
  logic               busy;
  logic               done;
  logic               w_load_en;
  logic [ROW_W-1:0]   w_load_row;
  logic               f_valid;
  logic [ROWS*N-1:0]  f_data;
  logic               f_ready;
  logic [ROWS*N-1:0]  sa_f;
  logic               compute_SA;
  logic [COLS-1:0]    out_valid;

  modport master (
    output start, cfg_len, f_valid, f_data,
    input  busy, done, w_load_en, w_load_row, f_ready, sa_f, compute_SA, out_valid
  );

  modport slave (
    input  start, cfg_len, f_valid, f_data,
    output busy, done, w_load_en, w_load_row, f_ready, sa_f, compute_SA, out_valid
  );

endinterface

// File: rtl/sa_skew_buf.sv
// Per-row delay line that skews a feature vector onto the array edge:
// row i is delayed by i enabled advances, row 0 passes straight through.
module sa_skew_buf
  import sa_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              en,
  input  logic [ROWS*N-1:0] din,
  output logic [ROWS*N-1:0] dout
);

  assign dout[N-1:0] = din[N-1:0];

  for (genvar i = 1; i < ROWS; i++) begin : g_row
    logic [N-1:0] dly_r [i];

    // Shift row i's delay line only when the array advances.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        for (int k = 0; k < i; k++) dly_r[k] <= '0;
      end else if (en) begin
        dly_r[0] <= din[i*N +: N];
        for (int k = 1; k < i; k++) dly_r[k] <= dly_r[k-1];
      end else begin
        for (int k = 0; k < i; k++) dly_r[k] <= dly_r[k];
      end
    end

    assign dout[i*N +: N] = dly_r[i-1];
  end

endmodule

// File: rtl/sa_ctrl.sv
// Weight-stationary systolic array controller: sequences weight load, feature
// streaming with stall, pipeline drain, and tracks per-column result validity.
module sa_ctrl
  import sa_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic    Clk,
  input  logic    Rst_n,
  sa_ctrl_if.slave bus
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DRAIN_N = drain_cyc(ROWS, COLS, MAC_LAT);
  localparam int DR_W    = cnt_w(DRAIN_N);
  localparam int TOK_D   = tok_depth(ROWS, COLS, MAC_LAT);
  localparam int TAP0    = ROWS - 1 + MAC_LAT;

  state_t            state_r, state_s;
  logic [LEN_W-1:0]  len_r, beat_cnt_r;
  logic [ROW_W-1:0]  ld_cnt_r;
  logic [DR_W-1:0]   dr_cnt_r;
  logic [TOK_D-2:0]  tok_r;
  logic [TOK_D-1:0]  tap_s;
  logic              idle_s, load_s, stream_s, drain_s, done_s;
  logic              beat_s, adv_s, last_beat_s, ld_last_s, dr_last_s;
  logic [ROWS*N-1:0] skew_in_s;

  assign idle_s   = (state_r == ST_IDLE);
  assign load_s   = (state_r == ST_LOAD_W);
  assign stream_s = (state_r == ST_STREAM);
  assign drain_s  = (state_r == ST_DRAIN);
  assign done_s   = (state_r == ST_DONE);

  assign beat_s      = stream_s & bus.f_valid;
  assign adv_s       = beat_s | drain_s;
  assign last_beat_s = beat_s && (beat_cnt_r == (len_r - LEN_W'(1)));
  assign ld_last_s   = (ld_cnt_r == ROW_W'(ROWS - 1));
  assign dr_last_s   = (dr_cnt_r == DR_W'(DRAIN_N - 1));

  // Tap k of the validity chain is the token from k advances ago; tap 0 is the live beat.
  assign tap_s = {tok_r, beat_s};

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_s = (bus.cfg_len == '0) ? ST_DONE : ST_LOAD_W;
        else           state_s = ST_IDLE;
      end
      ST_LOAD_W: begin
        if (ld_last_s) state_s = ST_STREAM;
        else           state_s = ST_LOAD_W;
      end
      ST_STREAM: begin
        if (last_beat_s) state_s = ST_DRAIN;
        else             state_s = ST_STREAM;
      end
      ST_DRAIN: begin
        if (dr_last_s) state_s = ST_DONE;
        else           state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Job length capture, phase counters and the validity token chain.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      len_r      <= '0;
      ld_cnt_r   <= '0;
      beat_cnt_r <= '0;
      dr_cnt_r   <= '0;
      tok_r      <= '0;
    end else begin
      if (idle_s && bus.start) len_r <= bus.cfg_len;
      else                     len_r <= len_r;

      if (load_s && !ld_last_s) ld_cnt_r <= ld_cnt_r + ROW_W'(1);
      else                      ld_cnt_r <= '0;

      if (beat_s)        beat_cnt_r <= beat_cnt_r + LEN_W'(1);
      else if (stream_s) beat_cnt_r <= beat_cnt_r;
      else               beat_cnt_r <= '0;

      if (drain_s && !dr_last_s) dr_cnt_r <= dr_cnt_r + DR_W'(1);
      else                       dr_cnt_r <= '0;

      if (adv_s) tok_r <= tap_s[TOK_D-2:0];
      else       tok_r <= tok_r;
    end
  end

  // Only accepted beats enter the skew; during drain zeros flush it.
  assign skew_in_s = beat_s ? bus.f_data : '0;

  sa_skew_buf #(
    .N    (N),
    .ROWS (ROWS)
  ) u_skew (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .en    (adv_s),
    .din   (skew_in_s),
    .dout  (bus.sa_f)
  );

  // Output decode from state and counters.
  always_comb begin
    bus.busy       = ~idle_s;
    bus.done       = done_s;
    bus.w_load_en  = load_s;
    bus.w_load_row = load_s ? ld_cnt_r : '0;
    bus.f_ready    = stream_s;
    bus.compute_SA = adv_s;
    for (int j = 0; j < COLS; j++) begin
      bus.out_valid[j] = (stream_s | drain_s) & tap_s[TAP0 + j];
    end
  end

endmodule

// File: doc/sa_ctrl.md
SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 Parameter N, 8, PE operand width (feature and weight bits).
REQ-002 Parameter ROWS, 8, systolic array rows (weight-stationary PE grid height).
REQ-003 Parameter COLS, 8, systolic array columns.
REQ-004 Parameter LEN_W, 12, width of the feature-vector count.
REQ-005 Parameter MAC_LAT, 1, extra pipeline cycles of the PE multiply-add before P is valid.
REQ-006 Clk  in  1  clock; all logic rising-edge.
REQ-007 Rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  single-cycle job request; honoured only in IDLE.
REQ-009 cfg_len  in  LEN_W  number of feature vectors in the job; sampled on accepted start.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse at job end.
REQ-012 w_load_en  out  1  weight-row write strobe to the array.
REQ-013 w_load_row  out  clog2(ROWS)  row index written when w_load_en is high.
REQ-014 f_valid  in  1  upstream feature vector present.
REQ-015 f_data  in  ROWS*N  feature vector, row 0 in LSBs.
REQ-016 f_ready  out  1  controller accepts f_data this cycle.
REQ-017 sa_f  out  ROWS*N  skewed feature inputs to array row edges.
REQ-018 compute_SA  out  1  array advance enable, wired to every PE.
REQ-019 out_valid  out  COLS  per-column flag: bottom P of column j holds a finished sum.

Function
REQ-020 FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE; encoding in shared package.
REQ-021 IDLE->LOAD_W on start with cfg_len!=0; IDLE->DONE on start with cfg_len==0; start outside IDLE ignored.
REQ-022 LOAD_W: w_load_en high exactly ROWS consecutive cycles, w_load_row 0..ROWS-1 ascending; then STREAM.
REQ-023 STREAM: f_ready=1; beat = f_valid&&f_ready; compute_SA = f_valid (array stalls, holding Next_F and P, when no beat).
REQ-024 Beat counter LEN_W bits; after cfg_len beats -> DRAIN; f_ready low in the cycle following the last beat.
REQ-025 DRAIN: compute_SA=1 and sa_f inputs zero for exactly ROWS+COLS-2+MAC_LAT cycles; then DONE.
REQ-026 DONE: done=1 for one cycle, busy=1, next state IDLE.
REQ-027 Skew: row i of sa_f equals the row-i lane of the beat accepted i compute_SA advances earlier; delay registers shift only when compute_SA=1.
REQ-028 Valid tracking: token shift register of depth ROWS+COLS-1+MAC_LAT, shifted only when compute_SA=1, token=1 on a beat; out_valid[j]=tap ROWS-1+MAC_LAT+j.
REQ-029 Exactly cfg_len pulses per column on out_valid per job; out_valid all zero in IDLE, LOAD_W, DONE.
REQ-030 compute_SA=0 in IDLE, LOAD_W, DONE.
REQ-031 cfg_len max (2^LEN_W-1) supported without counter wrap.

Reset
REQ-032 Rst_n low: state IDLE, counters, skew and token registers zero; busy, done, w_load_en, f_ready, compute_SA, out_valid, w_load_row, sa_f all zero.
REQ-033 Reset mid-job abandons it immediately; no done pulse; next start runs a full clean job.

Structure
REQ-034 Shared package sa_pkg: state enum, N/ROWS/COLS defaults, DRAIN_CYC = ROWS+COLS-2+MAC_LAT constant function.
REQ-035 One sub-module sa_skew_buf: per-row enable-gated delay line (row i depth i), instantiated once for features.
REQ-036 FSM, counters and token register live in sa_ctrl; no PE instances inside.

Verification
REQ-037 ROWS=COLS=4, MAC_LAT=1, start cfg_len=3, f_valid always 1 -> w_load_en 4 cycles rows 0..3, 3 beats, 7 drain cycles, done 15 cycles after start, 3 pulses per out_valid column.
REQ-038 Same config, f_valid toggling 1,0,1,0,1 -> compute_SA follows f_valid; sa_f and out_valid frozen on low cycles; results match golden matrix product.
REQ-039 start with cfg_len=0 -> done pulse on next cycle, no w_load_en, no compute_SA.
REQ-040 start pulsed again during STREAM -> ignored; beat count and done timing unchanged.
REQ-041 Rst_n low during DRAIN -> all outputs 0 next cycle, no done; subsequent cfg_len=2 job completes correctly.
REQ-042 cfg_len=4095 with LEN_W=12 -> exactly 4095 beats accepted, no early exit.
